mem_access_stage: RTL and testbench

Data-memory access stage between the EX/MEM pipeline register and the MEM/WB pipeline register (Mem_ExPipeline) of the RV32IM core. It performs RV32 loads and stores (byte, half, word) over a ready-handshaked data-memory port and aligns/extends load data. It stalls the upstream pipeline while an access is outstanding and presents the result fields that Mem_ExPipeline latches. Misaligned accesses and memory timeouts suppress the register write and are flagged.

---
 rtl/mem_access_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Data-memory access stage of the RV32IM core, sitting between EX/MEM and
//   Mem_ExPipeline. Issues byte/half/word loads and stores over a
//   ready-handshaked port, aligns and extends load data, stalls upstream
//   while an access is outstanding, and flags misaligned/illegal accesses
//   and memory timeouts.
// Ports:
//   CLK, Reset (async, active-low)
//   EX/MEM side : In_Valid, Memory_read, Memory_write, Funct3, ALU_Output,
//                 Store_Data, Write_enable, Write_Address, Stall
//   Memory port : Mem_Req, Mem_WE, Mem_Addr, Mem_Wdata, Mem_Wstrb,
//                 Mem_Ready, Mem_Rdata
//   To MEM/WB   : Write_Enable_Out, Memory_access_Out, Memory_Data_Out,
//                 ALU_Output_Out, Write_Address_out
//   Flags       : Misaligned_Fault, Bus_Error
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        In_Valid,
   input  logic        Memory_read,
   input  logic        Memory_write,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALU_Output,
   input  logic [31:0] Store_Data,
   input  logic        Write_enable,
   input  logic [4:0]  Write_Address,
   output logic        Stall,
   output logic        Mem_Req,
   output logic        Mem_WE,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_Wdata,
   output logic [3:0]  Mem_Wstrb,
   input  logic        Mem_Ready,
   input  logic [31:0] Mem_Rdata,
   output logic        Write_Enable_Out,
   output logic        Memory_access_Out,
   output logic [31:0] Memory_Data_Out,
   output logic [31:0] ALU_Output_Out,
   output logic [4:0]  Write_Address_out,
   output logic        Misaligned_Fault,
   output logic        Bus_Error
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q;
   logic [31:0]       addr_q;
   logic [31:0]       sdata_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic [4:0]        wa_q;
   logic              load_q;
   logic              err_q;
   logic [CNT_W-1:0]  timer_q;
   logic [31:0]       rdata_q;

   logic              mem_op;
   logic              is_store;
   logic              illegal;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_ext;

   // A request with both read and write set is a load.
   assign mem_op   = In_Valid & (Memory_read | Memory_write);
   assign is_store = Memory_write & ~Memory_read;

   always_comb begin
      illegal = 1'b0;
      unique case (Funct3)
         3'b000:  illegal = 1'b0;
         3'b001:  illegal = ALU_Output[0];
         3'b010:  illegal = (ALU_Output[1:0] != 2'b00);
         3'b100:  illegal = is_store;
         3'b101:  illegal = is_store | ALU_Output[0];
         default: illegal = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         sdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         wa_q     <= '0;
         load_q   <= 1'b0;
         err_q    <= 1'b0;
         timer_q  <= '0;
         rdata_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (mem_op && !illegal) begin
                  addr_q   <= ALU_Output;
                  sdata_q  <= Store_Data;
                  funct3_q <= Funct3;
                  we_q     <= Write_enable;
                  wa_q     <= Write_Address;
                  load_q   <= Memory_read;
                  err_q    <= 1'b0;
                  timer_q  <= '0;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (Mem_Ready) begin
                  rdata_q <= Mem_Rdata;
                  state_q <= S_DONE;
               end else if (timer_q == TIMER_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Load alignment and extension from the captured read word.
   always_comb begin
      ld_byte = 8'(rdata_q >> {addr_q[1:0], 3'b000});
      ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      unique case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = rdata_q;
      endcase
   end

   // Store lane encoding, held stable from captured regs through WAIT.
   always_comb begin
      Mem_Addr = {addr_q[31:2], 2'b00};
      unique case (funct3_q[1:0])
         2'b00: begin
            Mem_Wstrb = 4'b0001 << addr_q[1:0];
            Mem_Wdata = {4{sdata_q[7:0]}};
         end
         2'b01: begin
            Mem_Wstrb = 4'b0011 << {addr_q[1], 1'b0};
            Mem_Wdata = {2{sdata_q[15:0]}};
         end
         default: begin
            Mem_Wstrb = 4'b1111;
            Mem_Wdata = sdata_q;
         end
      endcase
      if (state_q != S_WAIT || load_q) Mem_Wstrb = 4'b0000;
   end

   always_comb begin
      Stall             = 1'b0;
      Mem_Req           = 1'b0;
      Mem_WE            = 1'b0;
      Write_Enable_Out  = 1'b0;
      Memory_access_Out = 1'b0;
      Memory_Data_Out   = '0;
      ALU_Output_Out    = addr_q;
      Write_Address_out = wa_q;
      Misaligned_Fault  = 1'b0;
      Bus_Error         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ALU_Output_Out    = ALU_Output;
            Write_Address_out = Write_Address;
            if (!mem_op) begin
               Write_Enable_Out = Write_enable & In_Valid;
            end else if (illegal) begin
               Misaligned_Fault = 1'b1;
            end else begin
               // Gated by reset so Stall drops as soon as reset asserts.
               Stall = Reset;
            end
         end
         S_WAIT: begin
            Stall   = 1'b1;
            Mem_Req = 1'b1;
            Mem_WE  = ~load_q;
         end
         S_DONE: begin
            Write_Enable_Out  = we_q & ~err_q;
            Memory_access_Out = load_q & ~err_q;
            Memory_Data_Out   = (load_q & ~err_q) ? ld_ext : '0;
            Bus_Error         = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        In_Valid, Memory_read, Memory_write;
   logic [2:0]  Funct3;
   logic [31:0] ALU_Output, Store_Data;
   logic        Write_enable;
   logic [4:0]  Write_Address;
   logic        Stall, Mem_Req, Mem_WE;
   logic [31:0] Mem_Addr, Mem_Wdata;
   logic [3:0]  Mem_Wstrb;
   logic        Mem_Ready;
   logic [31:0] Mem_Rdata;
   logic        Write_Enable_Out, Memory_access_Out;
   logic [31:0] Memory_Data_Out, ALU_Output_Out;
   logic [4:0]  Write_Address_out;
   logic        Misaligned_Fault, Bus_Error;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .CLK(CLK), .Reset(Reset), .In_Valid(In_Valid), .Memory_read(Memory_read),
      .Memory_write(Memory_write), .Funct3(Funct3), .ALU_Output(ALU_Output),
      .Store_Data(Store_Data), .Write_enable(Write_enable), .Write_Address(Write_Address),
      .Stall(Stall), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
      .Mem_Wdata(Mem_Wdata), .Mem_Wstrb(Mem_Wstrb), .Mem_Ready(Mem_Ready),
      .Mem_Rdata(Mem_Rdata), .Write_Enable_Out(Write_Enable_Out),
      .Memory_access_Out(Memory_access_Out), .Memory_Data_Out(Memory_Data_Out),
      .ALU_Output_Out(ALU_Output_Out), .Write_Address_out(Write_Address_out),
      .Misaligned_Fault(Misaligned_Fault), .Bus_Error(Bus_Error)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; lands 1 time unit after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic we, input logic [4:0] wa);
      In_Valid      = 1'b1;
      Memory_read   = rd;
      Memory_write  = wr;
      Funct3        = f3;
      ALU_Output    = addr;
      Store_Data    = sd;
      Write_enable  = we;
      Write_Address = wa;
   endtask

   task automatic clear_inputs();
      In_Valid = 1'b0; Memory_read = 1'b0; Memory_write = 1'b0;
      Funct3 = 3'b000; ALU_Output = '0; Store_Data = '0;
      Write_enable = 1'b0; Write_Address = '0;
   endtask

   // Single-wait-cycle load; leaves the bench in the DONE cycle.
   task automatic load_one(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] wa);
      drive(1'b1, 1'b0, f3, addr, 32'h0, 1'b1, wa);
      Mem_Ready = 1'b0;
      step();
      Mem_Ready = 1'b1;
      Mem_Rdata = rdata;
      step();
      Mem_Ready = 1'b0;
      Mem_Rdata = '0;
   endtask

   int n;

   initial begin
      clear_inputs();
      Mem_Ready = 1'b0;
      Mem_Rdata = '0;
      Reset = 1'b0;
      #1;
      chk("rst_req",   32'(Mem_Req), 32'd0);
      chk("rst_stall", 32'(Stall),   32'd0);
      chk("rst_weo",   32'(Write_Enable_Out), 32'd0);
      step(); step();
      Reset = 1'b1;
      step();

      // Non-memory pass-through
      drive(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1, 5'd3);
      #1;
      chk("pt_weo",  32'(Write_Enable_Out), 32'd1);
      chk("pt_alu",  ALU_Output_Out, 32'h55);
      chk("pt_wa",   32'(Write_Address_out), 32'd3);
      chk("pt_macc", 32'(Memory_access_Out), 32'd0);
      chk("pt_stall", 32'(Stall), 32'd0);
      clear_inputs();
      step();

      // SW 0xDEADBEEF -> 0x100, ready on first WAIT cycle
      drive(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, 5'd0);
      #1;
      chk("sw_idle_stall", 32'(Stall), 32'd1);
      chk("sw_idle_req",   32'(Mem_Req), 32'd0);
      step();
      Mem_Ready = 1'b1;
      #1;
      chk("sw_req",   32'(Mem_Req), 32'd1);
      chk("sw_we",    32'(Mem_WE), 32'd1);
      chk("sw_addr",  Mem_Addr, 32'h100);
      chk("sw_strb",  32'(Mem_Wstrb), 32'hF);
      chk("sw_wdata", Mem_Wdata, 32'hDEAD_BEEF);
      chk("sw_stall", 32'(Stall), 32'd1);
      step();
      Mem_Ready = 1'b0;
      #1;
      chk("sw_done_stall", 32'(Stall), 32'd0);
      chk("sw_done_weo",   32'(Write_Enable_Out), 32'd0);
      chk("sw_done_req",   32'(Mem_Req), 32'd0);
      chk("sw_done_berr",  32'(Bus_Error), 32'd0);
      clear_inputs();
      step();

      // LB / LBU from 0x203
      load_one(3'b000, 32'h203, 32'h80FF_7F01, 5'd9);
      #1;
      chk("lb_data", Memory_Data_Out, 32'hFFFF_FF80);
      chk("lb_weo",  32'(Write_Enable_Out), 32'd1);
      chk("lb_macc", 32'(Memory_access_Out), 32'd1);
      chk("lb_wa",   32'(Write_Address_out), 32'd9);
      chk("lb_alu",  ALU_Output_Out, 32'h203);
      clear_inputs();
      step();
      load_one(3'b100, 32'h203, 32'h80FF_7F01, 5'd10);
      #1;
      chk("lbu_data", Memory_Data_Out, 32'h0000_0080);
      clear_inputs();
      step();
      load_one(3'b000, 32'h201, 32'h80FF_7F01, 5'd10);
      #1;
      chk("lb1_data", Memory_Data_Out, 32'h0000_007F);
      clear_inputs();
      step();

      // SH 0x1234 -> 0x302
      drive(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_1234, 1'b0, 5'd0);
      step();
      Mem_Ready = 1'b1;
      #1;
      chk("sh_addr",  Mem_Addr, 32'h300);
      chk("sh_strb",  32'(Mem_Wstrb), 32'hC);
      chk("sh_wdata", Mem_Wdata, 32'h1234_1234);
      step();
      Mem_Ready = 1'b0;
      clear_inputs();
      step();

      // SB 0xA5 -> 0x101
      drive(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 1'b0, 5'd0);
      step();
      Mem_Ready = 1'b1;
      #1;
      chk("sb_strb",  32'(Mem_Wstrb), 32'h2);
      chk("sb_wdata", Mem_Wdata, 32'hA5A5_A5A5);
      step();
      Mem_Ready = 1'b0;
      clear_inputs();
      step();

      // LHU / LH from 0x302
      load_one(3'b101, 32'h302, 32'hABCD_0000, 5'd4);
      #1;
      chk("lhu_data", Memory_Data_Out, 32'h0000_ABCD);
      clear_inputs();
      step();
      load_one(3'b001, 32'h302, 32'hABCD_0000, 5'd4);
      #1;
      chk("lh_data", Memory_Data_Out, 32'hFFFF_ABCD);
      clear_inputs();
      step();

      // LW misaligned at 0x105
      drive(1'b1, 1'b0, 3'b010, 32'h105, 32'h0, 1'b1, 5'd7);
      #1;
      chk("mis_flag",  32'(Misaligned_Fault), 32'd1);
      chk("mis_req",   32'(Mem_Req), 32'd0);
      chk("mis_stall", 32'(Stall), 32'd0);
      chk("mis_weo",   32'(Write_Enable_Out), 32'd0);
      clear_inputs();
      step();
      chk("mis_after_flag", 32'(Misaligned_Fault), 32'd0);
      chk("mis_after_req",  32'(Mem_Req), 32'd0);

      // SB-unsigned encoding is illegal for stores
      drive(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1'b0, 5'd0);
      #1;
      chk("ill_st_flag", 32'(Misaligned_Fault), 32'd1);
      clear_inputs();
      step();

      // LW timeout: Mem_Ready never asserted
      drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 5'd12);
      step();
      n = 0;
      while (Mem_Req && n < 40) begin
         n++;
         step();
      end
      chk("to_req_cycles", 32'(n), 32'd16);
      chk("to_berr",  32'(Bus_Error), 32'd1);
      chk("to_weo",   32'(Write_Enable_Out), 32'd0);
      chk("to_macc",  32'(Memory_access_Out), 32'd0);
      chk("to_stall", 32'(Stall), 32'd0);
      chk("to_mis",   32'(Misaligned_Fault), 32'd0);
      clear_inputs();
      step();
      chk("to_after_berr", 32'(Bus_Error), 32'd0);

      // Reset asserted mid-WAIT
      drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b1, 5'd5);
      step();
      step();
      chk("rw_req_before", 32'(Mem_Req), 32'd1);
      Reset = 1'b0;
      #1;
      chk("rw_req",   32'(Mem_Req), 32'd0);
      chk("rw_stall", 32'(Stall), 32'd0);
      clear_inputs();
      step();
      Reset = 1'b1;
      step();
      #1;
      chk("rw_after_req", 32'(Mem_Req), 32'd0);
      chk("rw_after_weo", 32'(Write_Enable_Out), 32'd0);
      chk("rw_after_berr", 32'(Bus_Error), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
